// File: rtl/pacman_pkg.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | pacman_pkg: shared screen offsets, game-phase enum, pellet geometry.    |
// | Rev 1.0                                                                 |
// +-------------------------------------------------------------------------+
package pacman_pkg;

  localparam int OFFSETH = 274;
  localparam int OFFSETV = 58;

  localparam int PELLET_COLS       = 6;
  localparam int PELLET_ROWS       = 5;
  localparam int PELLET_GRID_X0    = 30;
  localparam int PELLET_GRID_Y0    = 30;
  localparam int PELLET_PITCH_LOG2 = 6;
  localparam int PELLET_HALF_W     = 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    WON  = 2'd2,
    LOST = 2'd3
  } game_state_t;

endpackage
`default_nettype wire

// File: rtl/pellet_score_if.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | pellet_score_if: pixel stream, game controls and score/phase outputs.   |
// | Rev 1.0                                                                 |
// +-------------------------------------------------------------------------+
interface pellet_score_if;
  logic        start;
  logic        ack;
  logic        lose;
  logic [9:0]  hCount;
  logic [9:0]  vCount;
  logic        pacmanFill;
  logic        pelletFill;
  logic [15:0] score;
  logic        win;
  logic        lost;

  modport master (
    output start, ack, lose, hCount, vCount, pacmanFill,
    input  pelletFill, score, win, lost
  );

  modport slave (
    input  start, ack, lose, hCount, vCount, pacmanFill,
    output pelletFill, score, win, lost
  );
endinterface
`default_nettype wire

// File: rtl/pellet_score_locator.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | pellet_locator: maps a VGA pixel to (on-pellet, pellet index).          |
// | Rev 1.0                                                                 |
// +-------------------------------------------------------------------------+
module pellet_locator
  import pacman_pkg::*;
#(
  parameter int COLS        = PELLET_COLS,
  parameter int ROWS        = PELLET_ROWS,
  parameter int GRID_X0     = PELLET_GRID_X0,
  parameter int GRID_Y0     = PELLET_GRID_Y0,
  parameter int PITCH_LOG2  = PELLET_PITCH_LOG2,
  parameter int PELLET_HALF = PELLET_HALF_W,
  parameter int IW          = $clog2(COLS * ROWS)
) (
  input  wire logic [9:0]    i_hCount,
  input  wire logic [9:0]    i_vCount,
  output logic               o_onPellet,
  output logic [IW-1:0]      o_idx
);

  localparam int CW = 11 - PITCH_LOG2;
  localparam logic signed [10:0]     c_XBIAS = 11'(OFFSETH + GRID_X0 - PELLET_HALF);
  localparam logic signed [10:0]     c_YBIAS = 11'(OFFSETV + GRID_Y0 - PELLET_HALF);
  localparam logic [PITCH_LOG2-1:0]  c_SPAN  = PITCH_LOG2'(2 * PELLET_HALF);
  localparam logic [CW-1:0]          c_COLS  = CW'(COLS);
  localparam logic [CW-1:0]          c_ROWS  = CW'(ROWS);

  logic signed [10:0] w_lx;
  logic signed [10:0] w_ly;
  logic [CW-1:0]      w_col;
  logic [CW-1:0]      w_row;

  // Bias puts each pellet's left/top edge at offset 0 within its pitch cell
  assign w_lx  = $signed({1'b0, i_hCount}) - c_XBIAS;
  assign w_ly  = $signed({1'b0, i_vCount}) - c_YBIAS;
  assign w_col = w_lx[10:PITCH_LOG2];
  assign w_row = w_ly[10:PITCH_LOG2];

  assign o_onPellet = !w_lx[10] && !w_ly[10]
                   && (w_lx[PITCH_LOG2-1:0] <= c_SPAN)
                   && (w_ly[PITCH_LOG2-1:0] <= c_SPAN)
                   && (w_col < c_COLS) && (w_row < c_ROWS);

  assign o_idx = IW'(w_row) * IW'(COLS) + IW'(w_col);

endmodule
`default_nettype wire

// File: rtl/pellet_score.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | pellet_score: pellet bitmap, saturating score and game-phase FSM.       |
// | Rev 1.0                                                                 |
// +-------------------------------------------------------------------------+
module pellet_score
  import pacman_pkg::*;
#(
  parameter int COLS          = PELLET_COLS,
  parameter int ROWS          = PELLET_ROWS,
  parameter int GRID_X0       = PELLET_GRID_X0,
  parameter int GRID_Y0       = PELLET_GRID_Y0,
  parameter int PITCH_LOG2    = PELLET_PITCH_LOG2,
  parameter int PELLET_HALF   = PELLET_HALF_W,
  parameter int PELLET_POINTS = 1,
  parameter int WIN_SCORE     = 30
) (
  input  wire logic      clk,
  input  wire logic      reset,
  pellet_score_if.slave  bus
);

  localparam int NPEL = COLS * ROWS;
  localparam int IW   = $clog2(NPEL);
  localparam logic [15:0] c_WIN = 16'(WIN_SCORE);
  localparam logic [16:0] c_PTS = 17'(PELLET_POINTS);

  game_state_t       r_state;
  game_state_t       w_state_nx;
  logic [NPEL-1:0]   r_bitmap;
  logic [NPEL-1:0]   w_bitmap_nx;
  logic [15:0]       r_score;
  logic [15:0]       w_score_nx;
  logic              r_win;
  logic              r_lost;
  logic              w_on;
  logic [IW-1:0]     w_idx;
  logic              w_live;
  logic [16:0]       w_sum;
  logic [15:0]       w_sat;

  pellet_locator #(
    .COLS(COLS), .ROWS(ROWS), .GRID_X0(GRID_X0), .GRID_Y0(GRID_Y0),
    .PITCH_LOG2(PITCH_LOG2), .PELLET_HALF(PELLET_HALF), .IW(IW)
  ) u_locator (
    .i_hCount   (bus.hCount),
    .i_vCount   (bus.vCount),
    .o_onPellet (w_on),
    .o_idx      (w_idx)
  );

  assign w_live = w_on && r_bitmap[w_idx];
  assign w_sum  = {1'b0, r_score} + c_PTS;
  assign w_sat  = w_sum[16] ? 16'hFFFF : w_sum[15:0];

  always_comb begin
    w_state_nx  = r_state;
    w_bitmap_nx = r_bitmap;
    w_score_nx  = r_score;
    case (r_state)
      IDLE: if (bus.start) w_state_nx = PLAY;
      PLAY: begin
        // lose wins over a same-cycle eat
        if (bus.lose) begin
          w_state_nx = LOST;
        end else if (bus.pacmanFill && w_live) begin
          w_bitmap_nx[w_idx] = 1'b0;
          w_score_nx         = w_sat;
          if (w_sat >= c_WIN) w_state_nx = WON;
        end
      end
      WON, LOST: begin
        if (bus.ack) begin
          w_state_nx  = IDLE;
          w_bitmap_nx = '1;
          w_score_nx  = '0;
        end
      end
      default: w_state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= IDLE;
      r_bitmap <= '1;
      r_score  <= '0;
      r_win    <= 1'b0;
      r_lost   <= 1'b0;
    end else begin
      r_state  <= w_state_nx;
      r_bitmap <= w_bitmap_nx;
      r_score  <= w_score_nx;
      r_win    <= (w_state_nx == WON);
      r_lost   <= (w_state_nx == LOST);
    end
  end

  assign bus.pelletFill = w_live && (r_state != WON) && (r_state != LOST);
  assign bus.score      = r_score;
  assign bus.win        = r_win;
  assign bus.lost       = r_lost;

endmodule
`default_nettype wire

// File: doc/pellet_score.md
Name: pellet_score

Overview:
- Sits beside pacman_movement in the game pipeline. It consumes pacmanFill, hCount and vCount, and produces score and win. Those two signals feed pacman_movement and the top-level game FSM.
- Holds a grid of pellets as a register bitmap and renders them through pelletFill.
- Detects the pixel overlap between Pac-Man and a live pellet, clears that pellet, and counts score.
- Runs a small game-phase FSM: IDLE, PLAY, WON, LOST. Leaving WON or LOST needs an ack handshake.

Parameters:
- COLS, 6, pellet columns.
- ROWS, 5, pellet rows.
- GRID_X0, 30, maze-space x of the column-0 pellet centre.
- GRID_Y0, 30, maze-space y of the row-0 pellet centre.
- PITCH_LOG2, 6, pellet pitch is 2^PITCH_LOG2 = 64 px in both axes.
- PELLET_HALF, 1, pellet is (2*PELLET_HALF+1) px square, so 3x3.
- PELLET_POINTS, 1, score added per pellet eaten.
- WIN_SCORE, 30, score at which the game is won. Must be <= COLS*ROWS*PELLET_POINTS.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- start  in  1  level; moves IDLE to PLAY
- ack  in  1  level; moves WON or LOST to IDLE
- lose  in  1  level from the ghost-collision logic
- hCount  in  10  VGA horizontal count, including blanking offset
- vCount  in  10  VGA vertical count, including blanking offset
- pacmanFill  in  1  current pixel is inside Pac-Man
- pelletFill  out  1  current pixel is a live pellet; combinational from hCount, vCount and the registered bitmap
- score  out  16  registered score
- win  out  1  registered; high while in WON
- lost  out  1  registered; high while in LOST

Behaviour:
- Reset: asynchronous, active-high. While asserted:
  - state is IDLE
  - bitmap is all ones (COLS*ROWS bits)
  - score is 0
  - win and lost are 0
  - pelletFill follows the restored bitmap immediately
- Screen-to-maze mapping:
  - lx = hCount - OFFSETH - GRID_X0 + PELLET_HALF
  - ly = vCount - OFFSETV - GRID_Y0 + PELLET_HALF
  - All arithmetic is 11-bit signed. Negative values are off-pellet.
  - col = lx >> PITCH_LOG2, row = ly >> PITCH_LOG2.
  - Pixel is on a pellet iff lx[PITCH_LOG2-1:0] <= 2*PELLET_HALF, the ly low bits meet the same test, col < COLS and row < ROWS.
  - idx = row*COLS + col.
- pelletFill = onPellet && bitmap[idx]. It is valid in every state except WON and LOST, where it is 0.
- Eat event (PLAY only): pacmanFill && onPellet && bitmap[idx] && !lose, sampled at a clk edge.
  - At that edge bitmap[idx] is cleared and score becomes score + PELLET_POINTS.
  - Both changes are visible the next cycle.
  - Further overlapping pixels of the same pellet see a cleared bit, so each pellet scores exactly once.
- Score saturates at 16'hFFFF. It never wraps.
- FSM transitions:
  - IDLE: start=1 goes to PLAY at the next edge. No eating in IDLE.
  - PLAY, lose=1: goes to LOST. lose has priority over a same-cycle eat, which is discarded (no clear, no score).
  - PLAY, eat event where the new score >= WIN_SCORE: goes to WON at the same edge the score updates, so win=1 one cycle after the final eat.
  - PLAY, start: ignored.
  - WON: win=1. Score and bitmap are frozen; lose and pacmanFill are ignored.
  - LOST: lost=1. Score and bitmap are frozen.
  - WON or LOST with ack=1: goes to IDLE at the next edge. At that edge score is 0, the bitmap is all ones, and win and lost are 0.
  - start is ignored while in WON or LOST.
- Simultaneous ack and start in WON: go to IDLE only. A new start is needed afterwards.
- Reset mid-operation takes effect immediately, with no waiting for frame or clock.

Decomposition:
- pacman_pkg holds the shared constants and types:
  - OFFSETH = 274 and OFFSETV = 58, also used by pacman_movement
  - the game-state enum: IDLE, PLAY, WON, LOST
  - pellet-geometry localparams
- One sub-module, pellet_locator: purely combinational. It maps (hCount, vCount) to (onPellet, idx[$clog2(COLS*ROWS)-1:0]).
- The bitmap, score counter and FSM live in pellet_score.

Test Plan:
- Reset, then hCount=304, vCount=88 (pellet 0 centre): pelletFill=1, score=0, win=0, lost=0.
- start, then pacmanFill=1 at (304,88) for 4 cycles: score=1 from the next cycle and never higher; pelletFill at (304,88) becomes 0.
- In PLAY, pacmanFill=1 at (307,88) (offset 3 > 2): score unchanged, pelletFill=0 at that pixel; pellet 1 at (368,88) is still lit.
- Eat all 30 pellets in sequence: win=1 exactly one cycle after the 30th eat; further pacmanFill leaves score=30. Then ack: next cycle win=0, score=0, pelletFill=1 at (304,88).
- In PLAY with score=5, eat and lose in the same cycle: score stays 5, pellet not cleared, lost=1. start is ignored until ack.
- In PLAY with score=7, assert reset between clock edges: score=0 and state IDLE immediately, with no clock edge needed; all pellets render.
